// File: rtl/bbs_stream_ctrl.sv
// Stream sequencer for the bbs generator: loads one configuration, runs the generator,
// packs its serial bits into W-bit words and hands them out on a valid/ready stream.
module bbs_stream_ctrl #(
    parameter int M     = 1024,
    parameter int W     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             abort,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [M-1:0]     cfg_seed,
    input  logic [M-1:0]     cfg_C,
    input  logic [M-1:0]     cfg_N,
    input  logic [M-1:0]     cfg_n,
    input  logic [CNT_W-1:0] cfg_words,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_word,
    output logic             done,
    output logic             busy,
    output logic             err,
    output logic             bbs_load,
    output logic             bbs_start,
    output logic [M-1:0]     bbs_seed,
    output logic [M-1:0]     bbs_C,
    output logic [M-1:0]     bbs_N,
    output logic [M-1:0]     bbs_n,
    input  logic             bbs_bit,
    input  logic             bbs_bit_valid
);

    localparam int BC_W = (W > 1) ? $clog2(W) : 1;
    localparam logic [BC_W-1:0] BIT_LAST = BC_W'(W - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_STALL = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [W-1:0]     shift_q, shift_d;
    logic [BC_W-1:0]  bitcnt_q, bitcnt_d;
    logic [CNT_W-1:0] words_q, words_d;
    logic [W-1:0]     out_word_q, out_word_d;
    logic             out_valid_q, out_valid_d;
    logic             err_q, err_d;
    logic [M-1:0]     seed_q, mont_c_q, mod_q, mod_len_q;

    logic             accept;
    logic             handshake;
    logic             word_full;
    logic [W-1:0]     shifted;
    logic [CNT_W-1:0] words_dec;

    assign accept    = (state_q == S_IDLE) && cfg_valid && !abort;
    assign handshake = out_valid_q && out_ready;
    assign word_full = (bitcnt_q == BIT_LAST);
    assign shifted   = {shift_q[W-2:0], bbs_bit};
    assign words_dec = (words_q != '0) ? words_q - CNT_W'(1) : '0;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bitcnt_d    = bitcnt_q;
        words_d     = words_q;
        out_word_d  = out_word_q;
        out_valid_d = out_valid_q;
        // Any bit offered while the generator is not enabled is dropped and flagged.
        err_d       = err_q | (bbs_bit_valid && (state_q != S_RUN));

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    words_d  = cfg_words;
                    bitcnt_d = '0;
                    shift_d  = '0;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = (words_q == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (handshake) out_valid_d = 1'b0;
                if (bbs_bit_valid) begin
                    shift_d  = shifted;
                    bitcnt_d = word_full ? '0 : bitcnt_q + BC_W'(1);
                    if (word_full) begin
                        if (!out_valid_q || out_ready) begin
                            out_word_d  = shifted;
                            out_valid_d = 1'b1;
                            words_d     = words_dec;
                            if (words_dec == '0) state_d = S_DRAIN;
                        end else begin
                            state_d = S_STALL;
                        end
                    end
                end
            end
            S_STALL: begin
                // The full word waits in the shift register until the output slot frees.
                if (handshake) begin
                    out_word_d = shift_q;
                    words_d    = words_dec;
                    state_d    = (words_dec == '0) ? S_DRAIN : S_RUN;
                end
            end
            S_DRAIN: begin
                if (handshake) begin
                    out_valid_d = 1'b0;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                out_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            shift_d     = '0;
            bitcnt_d    = '0;
            words_d     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            shift_q     <= '0;
            bitcnt_q    <= '0;
            words_q     <= '0;
            out_word_q  <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bitcnt_q    <= bitcnt_d;
            words_q     <= words_d;
            out_word_q  <= out_word_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    // Operands survive abort and run completion; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            seed_q    <= '0;
            mont_c_q  <= '0;
            mod_q     <= '0;
            mod_len_q <= '0;
        end else if (accept) begin
            seed_q    <= cfg_seed;
            mont_c_q  <= cfg_C;
            mod_q     <= cfg_N;
            mod_len_q <= cfg_n;
        end
    end

    assign cfg_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign bbs_load  = (state_q == S_LOAD);
    assign bbs_start = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign out_valid = out_valid_q;
    assign out_word  = out_word_q;
    assign err       = err_q;
    assign bbs_seed  = seed_q;
    assign bbs_C     = mont_c_q;
    assign bbs_N     = mod_q;
    assign bbs_n     = mod_len_q;

endmodule

// File: tb/tb_bbs_stream_ctrl.sv
// Self-checking bench for bbs_stream_ctrl: directed timing sequences, a vector table,
// and randomized runs compared against a bit-list-to-word reference model.
module tb_bbs_stream_ctrl;

    localparam int TM   = 128;
    localparam int TW   = 8;
    localparam int TCW  = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            abort = 1'b0;
    logic            cfg_valid = 1'b0;
    logic            cfg_ready;
    logic [TM-1:0]   cfg_seed = '0;
    logic [TM-1:0]   cfg_C = '0;
    logic [TM-1:0]   cfg_N = '0;
    logic [TM-1:0]   cfg_n = '0;
    logic [TCW-1:0]  cfg_words = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [TW-1:0]   out_word;
    logic            done;
    logic            busy;
    logic            err;
    logic            bbs_load;
    logic            bbs_start;
    logic [TM-1:0]   bbs_seed, bbs_C, bbs_N, bbs_n;
    logic            bbs_bit = 1'b0;
    logic            bbs_bit_valid = 1'b0;

    bbs_stream_ctrl #(.M(TM), .W(TW), .CNT_W(TCW)) dut (
        .clk(clk), .rst(rst), .abort(abort),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_seed(cfg_seed), .cfg_C(cfg_C), .cfg_N(cfg_N), .cfg_n(cfg_n), .cfg_words(cfg_words),
        .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
        .done(done), .busy(busy), .err(err),
        .bbs_load(bbs_load), .bbs_start(bbs_start),
        .bbs_seed(bbs_seed), .bbs_C(bbs_C), .bbs_N(bbs_N), .bbs_n(bbs_n),
        .bbs_bit(bbs_bit), .bbs_bit_valid(bbs_bit_valid)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    int          done_cnt = 0;
    logic [7:0]  got_q[$];
    logic        stim_q[$];

    typedef struct {
        int          nwords;
        logic [23:0] bits;
        int          ready_mode;
        logic [7:0]  exp0;
        logic [7:0]  exp1;
        logic [7:0]  exp2;
    } vec_t;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Output monitor: records accepted words, counts done pulses, checks word stability under backpressure.
    initial begin
        logic       hold_pending = 1'b0;
        logic [7:0] held_word = '0;
        logic       ctl_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_pending = 1'b0;
            end else begin
                if (hold_pending && !ctl_prev) begin
                    check("hold_valid", 128'(out_valid), 128'(1));
                    check("hold_word", 128'(out_word), 128'(held_word));
                end
                hold_pending = out_valid && !out_ready;
                held_word    = out_word;
                ctl_prev     = abort;
                if (out_valid && out_ready) begin
                    got_q.push_back(out_word);
                    $display("[TB] word %02h accepted", out_word);
                end
                if (done) done_cnt++;
            end
        end
    end

    // Generator stub plus consumer until a done pulse or the cycle budget runs out.
    task automatic feed_until_done(input int ready_mode, input int budget);
        int start_cnt = done_cnt;
        for (int cyc = 0; cyc < budget; cyc++) begin
            if (done_cnt != start_cnt) break;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = (cyc >= 40);
            endcase
            if (bbs_start && stim_q.size() > 0 && $urandom_range(0, 3) != 0) begin
                bbs_bit_valid = 1'b1;
                bbs_bit       = stim_q.pop_front();
            end else begin
                bbs_bit_valid = 1'b0;
            end
            step();
        end
        bbs_bit_valid = 1'b0;
        check("run_done_once", 128'(done_cnt - start_cnt), 128'(1));
    endtask

    task automatic run_words(input int nwords, input int ready_mode);
        got_q.delete();
        cfg_words = TCW'(nwords);
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        feed_until_done(ready_mode, 3000);
        check("run_idle_after", 128'(busy), 128'(0));
        check("run_bits_used", 128'(stim_q.size()), 128'(0));
        check("run_err_clear", 128'(err), 128'(0));
        $display("[TB] run of %0d words mode %0d collected %0d words", nwords, ready_mode, got_q.size());
    endtask

    initial begin
        vec_t        vecs[5];
        logic [15:0] seq;
        logic [23:0] seq3;
        logic [7:0]  exp_q[$];
        int          start_cnt;

        vecs[0] = '{1, 24'b1010_0101_0000_0000_0000_0000, 0, 8'hA5, 8'h00, 8'h00};
        vecs[1] = '{2, 24'b0011_1100_1000_0001_0000_0000, 1, 8'h3C, 8'h81, 8'h00};
        vecs[2] = '{3, 24'b1111_1111_0000_0000_0111_1110, 2, 8'hFF, 8'h00, 8'h7E};
        vecs[3] = '{0, 24'b0000_0000_0000_0000_0000_0000, 0, 8'h00, 8'h00, 8'h00};
        vecs[4] = '{3, 24'b0001_0010_0011_0100_0101_0110, 1, 8'h12, 8'h34, 8'h56};

        // Reset state
        step();
        step();
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_cfg_ready", 128'(cfg_ready), 128'(1));
        check("rst_bbs_start", 128'(bbs_start), 128'(0));
        check("rst_bbs_load", 128'(bbs_load), 128'(0));
        check("rst_err", 128'(err), 128'(0));
        rst = 1'b0;
        step();

        // Load timing and packing with two words
        cfg_seed  = 128'd323809140;
        cfg_N     = 128'd1200000003730000000273;
        cfg_n     = 128'd71;
        cfg_C     = 128'd448256546290935196720;
        cfg_words = 16'd2;
        cfg_valid = 1'b1;
        out_ready = 1'b1;
        got_q.delete();
        start_cnt = done_cnt;
        check("t2_ready_at_t", 128'(cfg_ready), 128'(1));
        check("t2_load_at_t", 128'(bbs_load), 128'(0));
        step();
        cfg_valid = 1'b0;
        check("t2_load_t1", 128'(bbs_load), 128'(1));
        check("t2_start_t1", 128'(bbs_start), 128'(0));
        check("t2_seed", bbs_seed, 128'd323809140);
        check("t2_N", bbs_N, 128'd1200000003730000000273);
        check("t2_n", bbs_n, 128'd71);
        check("t2_C", bbs_C, 128'd448256546290935196720);
        step();
        check("t2_load_t2", 128'(bbs_load), 128'(0));
        check("t2_start_t2", 128'(bbs_start), 128'(1));
        seq = 16'b1011_0010_0100_0001;
        for (int i = 0; i < 16; i++) begin
            bbs_bit_valid = 1'b1;
            bbs_bit       = seq[15-i];
            step();
            if (i == 7) begin
                check("t3_word1_valid", 128'(out_valid), 128'(1));
                check("t3_word1", 128'(out_word), 128'(8'hB2));
            end
        end
        bbs_bit_valid = 1'b0;
        check("t3_word2", 128'(out_word), 128'(8'h41));
        check("t3_drain_start", 128'(bbs_start), 128'(0));
        step();
        check("t3_done", 128'(done), 128'(1));
        step();
        check("t3_done_low", 128'(done), 128'(0));
        check("t3_busy_low", 128'(busy), 128'(0));
        check("t3_done_count", 128'(done_cnt - start_cnt), 128'(1));
        check("t3_word_count", 128'(got_q.size()), 128'(2));

        // Backpressure into STALL, stray bit sets err, then release
        out_ready = 1'b0;
        got_q.delete();
        cfg_words = 16'd3;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        step();
        seq3 = 24'b1100_0011_0101_1010_0000_1111;
        for (int i = 0; i < 16; i++) begin
            bbs_bit_valid = 1'b1;
            bbs_bit       = seq3[23-i];
            step();
        end
        bbs_bit_valid = 1'b0;
        check("t4_stall_start", 128'(bbs_start), 128'(0));
        check("t4_stall_busy", 128'(busy), 128'(1));
        check("t4_stall_word", 128'(out_word), 128'(8'hC3));
        step();
        step();
        check("t4_stall_word_later", 128'(out_word), 128'(8'hC3));
        check("t4_err_before", 128'(err), 128'(0));
        bbs_bit_valid = 1'b1;
        bbs_bit       = 1'b1;
        step();
        bbs_bit_valid = 1'b0;
        check("t5_err_set", 128'(err), 128'(1));
        stim_q.delete();
        for (int i = 16; i < 24; i++) stim_q.push_back(seq3[23-i]);
        feed_until_done(0, 500);
        check("t4_count", 128'(got_q.size()), 128'(3));
        if (got_q.size() == 3) begin
            check("t4_w1", 128'(got_q[0]), 128'(8'hC3));
            check("t4_w2", 128'(got_q[1]), 128'(8'h5A));
            check("t4_w3", 128'(got_q[2]), 128'(8'h0F));
        end
        check("t5_err_sticky", 128'(err), 128'(1));

        // Zero-word configuration
        got_q.delete();
        cfg_words = 16'd0;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        check("t5_zero_load", 128'(bbs_load), 128'(1));
        check("t5_zero_nodone", 128'(done), 128'(0));
        step();
        check("t5_zero_done", 128'(done), 128'(1));
        check("t5_zero_noval", 128'(out_valid), 128'(0));
        step();
        check("t5_zero_idle", 128'(busy), 128'(0));
        check("t5_zero_nowords", 128'(got_q.size()), 128'(0));

        // Reset in the middle of a run
        cfg_words = 16'd2;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            bbs_bit_valid = 1'b1;
            bbs_bit       = 1'b1;
            step();
        end
        bbs_bit_valid = 1'b0;
        rst = 1'b1;
        step();
        check("t1_mid_busy", 128'(busy), 128'(0));
        check("t1_mid_cfg_ready", 128'(cfg_ready), 128'(1));
        check("t1_mid_err", 128'(err), 128'(0));
        check("t1_mid_start", 128'(bbs_start), 128'(0));
        check("t1_mid_valid", 128'(out_valid), 128'(0));
        check("t1_mid_N", bbs_N, 128'd0);
        rst = 1'b0;
        step();

        // Abort with a partial word, then a fresh run
        start_cnt = done_cnt;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            bbs_bit_valid = 1'b1;
            bbs_bit       = 1'($urandom_range(0, 1));
            step();
        end
        bbs_bit_valid = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t6_abort_idle", 128'(busy), 128'(0));
        check("t6_abort_start", 128'(bbs_start), 128'(0));
        check("t6_abort_valid", 128'(out_valid), 128'(0));
        check("t6_abort_N_kept", bbs_N, 128'd1200000003730000000273);
        step();
        check("t6_abort_nodone", 128'(done_cnt - start_cnt), 128'(0));
        stim_q.delete();
        seq = 16'b1110_0001_0110_1001;
        for (int i = 0; i < 16; i++) stim_q.push_back(seq[15-i]);
        run_words(2, 0);
        check("t6_fresh_count", 128'(got_q.size()), 128'(2));
        if (got_q.size() == 2) begin
            check("t6_fresh_w1", 128'(got_q[0]), 128'(8'hE1));
            check("t6_fresh_w2", 128'(got_q[1]), 128'(8'h69));
        end

        // Vector table
        for (int v = 0; v < 5; v++) begin
            stim_q.delete();
            for (int i = 0; i < vecs[v].nwords * 8; i++) stim_q.push_back(vecs[v].bits[23-i]);
            run_words(vecs[v].nwords, vecs[v].ready_mode);
            check("vec_count", 128'(got_q.size()), 128'(vecs[v].nwords));
            if (got_q.size() > 0) check("vec_w0", 128'(got_q[0]), 128'(vecs[v].exp0));
            if (got_q.size() > 1) check("vec_w1", 128'(got_q[1]), 128'(vecs[v].exp1));
            if (got_q.size() > 2) check("vec_w2", 128'(got_q[2]), 128'(vecs[v].exp2));
        end

        // Randomized runs against the chunking model
        for (int r = 0; r < 12; r++) begin
            int n    = $urandom_range(0, 5);
            int mode = $urandom_range(0, 2);
            stim_q.delete();
            exp_q.delete();
            for (int k = 0; k < n; k++) begin
                int val = $urandom_range(0, 255);
                exp_q.push_back(8'(val));
                for (int b = 7; b >= 0; b--) stim_q.push_back(((val >> b) & 1) == 1);
            end
            run_words(n, mode);
            check("rnd_count", 128'(got_q.size()), 128'(n));
            for (int k = 0; k < n && k < got_q.size(); k++)
                check("rnd_word", 128'(got_q[k]), 128'(exp_q[k]));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
